// File: rtl/turn_pkg.sv
// turn_pkg: state encoding, key constants and wind LFSR definition shared by
// turn_scheduler, its sub-module and the HUD.
package turn_pkg;

  typedef enum logic [2:0] {
    PLAY   = 3'd0,
    FIRED  = 3'd1,
    SETTLE = 3'd2,
    SWITCH = 3'd3,
    OVER   = 3'd4
  } turn_state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 seen from the output end of a right-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/turn_next_picker.sv
// turn_next_picker: from the current player and the dead mask, finds the next
// living player (round-robin), the number of living players and the lowest
// living index.
module turn_next_picker
  import turn_pkg::*;
#(
  parameter int NUM_PLAYERS = 2
) (
  input  logic [1:0]             cur_idx_i,
  input  logic [NUM_PLAYERS-1:0] dead_i,
  output logic [1:0]             next_idx_o,
  output logic [2:0]             alive_cnt_o,
  output logic [1:0]             lowest_idx_o
);

  logic [1:0] after_idx;
  logic       after_found;
  logic       low_found;

  // First living index above the current one, else wrap to the lowest living.
  always_comb begin
    alive_cnt_o  = '0;
    lowest_idx_o = '0;
    after_idx    = '0;
    after_found  = 1'b0;
    low_found    = 1'b0;
    for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
      if (!dead_i[j]) begin
        alive_cnt_o = alive_cnt_o + 3'd1;
        if (!low_found) begin
          lowest_idx_o = 2'(j);
          low_found    = 1'b1;
        end
        if (!after_found && (j > 32'(cur_idx_i))) begin
          after_idx   = 2'(j);
          after_found = 1'b1;
        end
      end
    end
    next_idx_o = after_found ? after_idx : lowest_idx_o;
  end

endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: per-frame turn controller. Gates the keyboard to the active
// player, ends turns on launch, timeout or death, waits for bombs and terrain
// to settle, then hands over round-robin to the next living player.
// Optional wind generator enabled by defining TURN_SCHED_WIND_EN.
module turn_scheduler
  import turn_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int TURN_FRAMES   = 600,
  parameter int SETTLE_FRAMES = 60
) (
  input  logic                     frame_clk,
  input  logic                     reset,
  input  logic [7:0]               keycode,
  input  logic                     bomb_busy,
  input  logic [NUM_PLAYERS-1:0]   player_dead,
  output logic [NUM_PLAYERS*8-1:0] keycode_p,
  output logic [1:0]               active_player,
  output logic [9:0]               turn_timer,
  output logic [2:0]               phase,
  output logic                     game_over,
  output logic [1:0]               winner,
  output logic [3:0]               wind
);

  localparam logic [9:0] TIMER_LOAD  = 10'(TURN_FRAMES);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_FRAMES);

  turn_state_t state_q;
  logic [1:0]  active_q;
  logic [1:0]  winner_q;
  logic [9:0]  timer_q;
  logic [7:0]  settle_q;
  logic        bomb_prev_q;
  logic        game_over_q;

  logic [1:0]  next_idx;
  logic [2:0]  alive_cnt;
  logic [1:0]  lowest_idx;
  logic        active_dead;
  logic        launch;
  logic        end_game;

  turn_next_picker #(.NUM_PLAYERS(NUM_PLAYERS)) u_picker (
    .cur_idx_i    (active_q),
    .dead_i       (player_dead),
    .next_idx_o   (next_idx),
    .alive_cnt_o  (alive_cnt),
    .lowest_idx_o (lowest_idx)
  );

  // Dead bit of the active player, selected without a variable-width index.
  always_comb begin
    active_dead = 1'b0;
    for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
      if (2'(j) == active_q) active_dead = player_dead[j];
    end
  end

  assign launch   = bomb_busy & ~bomb_prev_q;
  assign end_game = (alive_cnt <= 3'd1);

  // Turn FSM with registered HUD outputs.
  always_ff @(posedge frame_clk or posedge reset) begin
    if (reset) begin
      state_q     <= PLAY;
      active_q    <= '0;
      timer_q     <= TIMER_LOAD;
      settle_q    <= '0;
      bomb_prev_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= '0;
    end else begin
      bomb_prev_q <= bomb_busy;
      case (state_q)
        PLAY: begin
          if (active_dead) begin
            state_q  <= SETTLE;
            settle_q <= SETTLE_LOAD;
          end else if (launch) begin
            state_q <= FIRED;
          end else if (timer_q == '0) begin
            state_q  <= SETTLE;
            settle_q <= SETTLE_LOAD;
          end else begin
            timer_q <= timer_q - 10'd1;
          end
        end
        FIRED: begin
          if (!bomb_busy) begin
            state_q  <= SETTLE;
            settle_q <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          // Last settle frame is held while a bomb is still airborne.
          if (settle_q <= 8'd1) begin
            if (!bomb_busy) begin
              state_q  <= SWITCH;
              settle_q <= '0;
            end
          end else begin
            settle_q <= settle_q - 8'd1;
          end
        end
        SWITCH: begin
          if (end_game) begin
            state_q     <= OVER;
            game_over_q <= 1'b1;
            winner_q    <= lowest_idx;
          end else begin
            state_q  <= PLAY;
            active_q <= next_idx;
            timer_q  <= TIMER_LOAD;
          end
        end
        OVER:    state_q <= OVER;
        default: state_q <= PLAY;
      endcase
    end
  end

  // Only the active player sees the live keycode, and only while playing.
  always_comb begin
    keycode_p = '0;
    if (state_q == PLAY) begin
      for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
        if (2'(j) == active_q) keycode_p[j*8 +: 8] = keycode;
      end
    end
  end

  assign active_player = active_q;
  assign turn_timer    = timer_q;
  assign phase         = state_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;

`ifdef TURN_SCHED_WIND_EN
  logic [15:0] lfsr_q;
  logic [3:0]  wind_q;
  logic        switch_to_play;

  assign switch_to_play = (state_q == SWITCH) && !end_game;

  // Free-running LFSR; wind is sampled on each new turn, -8 folded to 0.
  always_ff @(posedge frame_clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
      wind_q <= '0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      if (switch_to_play) begin
        wind_q <= (lfsr_q[3:0] == 4'b1000) ? 4'b0000 : lfsr_q[3:0];
      end
    end
  end

  assign wind = wind_q;
`else
  assign wind = '0;
`endif

endmodule

// File: tb/tb_turn_scheduler.sv
// tb_turn_scheduler: directed sequences on a default 2-player instance, a
// vector table and a randomized run against a reference model on a 3-player
// instance with short turns.
module tb_turn_scheduler;
  import turn_pkg::*;

  localparam int NB = 3;
  localparam int TB = 5;
  localparam int SB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: defaults (2 players, 600-frame turns, 60-frame settle)
  logic        a_rst = 1'b1;
  logic [7:0]  a_kc = '0;
  logic        a_bomb = 1'b0;
  logic [1:0]  a_dead = '0;
  logic [15:0] a_kcp;
  logic [1:0]  a_act;
  logic [9:0]  a_tmr;
  logic [2:0]  a_ph;
  logic        a_go;
  logic [1:0]  a_win;
  logic [3:0]  a_wind;

  turn_scheduler dut_a (
    .frame_clk     (clk),
    .reset         (a_rst),
    .keycode       (a_kc),
    .bomb_busy     (a_bomb),
    .player_dead   (a_dead),
    .keycode_p     (a_kcp),
    .active_player (a_act),
    .turn_timer    (a_tmr),
    .phase         (a_ph),
    .game_over     (a_go),
    .winner        (a_win),
    .wind          (a_wind)
  );

  // Instance B: 3 players, short turns
  logic          b_rst = 1'b1;
  logic [7:0]    b_kc = '0;
  logic          b_bomb = 1'b0;
  logic [NB-1:0] b_dead = '0;
  logic [NB*8-1:0] b_kcp;
  logic [1:0]    b_act;
  logic [9:0]    b_tmr;
  logic [2:0]    b_ph;
  logic          b_go;
  logic [1:0]    b_win;
  logic [3:0]    b_wind;

  turn_scheduler #(.NUM_PLAYERS(NB), .TURN_FRAMES(TB), .SETTLE_FRAMES(SB)) dut_b (
    .frame_clk     (clk),
    .reset         (b_rst),
    .keycode       (b_kc),
    .bomb_busy     (b_bomb),
    .player_dead   (b_dead),
    .keycode_p     (b_kcp),
    .active_player (b_act),
    .turn_timer    (b_tmr),
    .phase         (b_ph),
    .game_over     (b_go),
    .winner        (b_win),
    .wind          (b_wind)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_wind(input string name, input logic [3:0] w);
`ifdef TURN_SCHED_WIND_EN
    check(name, 32'(w == 4'b1000), 32'd0);
`else
    check(name, 32'(w), 32'd0);
`endif
  endtask

  task automatic frame();
    @(negedge clk);
    #1;
  endtask

  // Reference model for instance B: turns counted in elapsed frames
  turn_state_t m_phase;
  int          m_active, m_elapsed, m_settled, m_winner;
  bit          m_prev, m_over;

  task automatic model_reset();
    m_phase = PLAY; m_active = 0; m_elapsed = 0; m_settled = 0;
    m_prev = 0; m_over = 0; m_winner = 0;
  endtask

  task automatic model_step(input bit bomb, input logic [NB-1:0] dead);
    int alive;
    int nxt;
    case (m_phase)
      PLAY: begin
        if (dead[m_active]) begin m_phase = SETTLE; m_settled = 0; end
        else if (bomb && !m_prev) m_phase = FIRED;
        else if (m_elapsed == TB) begin m_phase = SETTLE; m_settled = 0; end
        else m_elapsed++;
      end
      FIRED: if (!bomb) begin m_phase = SETTLE; m_settled = 0; end
      SETTLE: begin
        m_settled++;
        if (m_settled >= SB && !bomb) m_phase = SWITCH;
      end
      SWITCH: begin
        alive = NB - $countones(dead);
        if (alive <= 1) begin
          m_phase = OVER; m_over = 1; m_winner = 0;
          for (int i = NB - 1; i >= 0; i--) if (!dead[i]) m_winner = i;
        end else begin
          nxt = m_active;
          for (int s = NB - 1; s >= 1; s--) if (!dead[(m_active + s) % NB]) nxt = (m_active + s) % NB;
          m_active = nxt; m_elapsed = 0; m_phase = PLAY;
        end
      end
      default: ;
    endcase
    m_prev = bomb;
  endtask

  function automatic logic [NB*8-1:0] exp_kcp(input turn_state_t ph, input int act, input logic [7:0] kc);
    logic [NB*8-1:0] r;
    r = '0;
    if (ph == PLAY) r[act*8 +: 8] = kc;
    return r;
  endfunction

  typedef struct {
    logic        bomb;
    logic [2:0]  dead;
    logic [7:0]  kc;
    turn_state_t ph;
    int          act;
    int          tmr;
    logic        go;
    int          win;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic bomb, input logic [2:0] dead, input logic [7:0] kc,
                     input turn_state_t ph, input int act, input int tmr,
                     input logic go, input int win);
    vec_t v;
    v.bomb = bomb; v.dead = dead; v.kc = kc; v.ph = ph;
    v.act = act; v.tmr = tmr; v.go = go; v.win = win;
    tv.push_back(v);
  endtask

  logic [2:0] hist [0:101];
  logic [2:0] hist2 [0:69];

  initial begin
    int n_fired, n_settle, n_switch, first_fired;

    // ---------------- Instance A: reset state ----------------
    a_rst = 1'b1; a_kc = 8'h07; a_bomb = 1'b0; a_dead = '0;
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
    #1;
    check("A reset kcp0", 32'(a_kcp[7:0]), 32'h07);
    check("A reset kcp1", 32'(a_kcp[15:8]), 32'h00);
    check("A reset phase", 32'(a_ph), 32'(PLAY));
    check("A reset timer", 32'(a_tmr), 32'd600);
    check("A reset active", 32'(a_act), 32'd0);
    check("A reset game_over", 32'(a_go), 32'd0);
    check("A reset winner", 32'(a_win), 32'd0);
    check("A reset wind", 32'(a_wind), 32'd0);

    // ---------------- Instance A: launch at frame 10 for 30 frames ----------------
    for (int f = 0; f < 102; f++) begin
      hist[f] = a_ph;
      a_bomb = (f >= 10 && f < 40);
      frame();
    end
    a_bomb = 1'b0;
    n_fired = 0; n_settle = 0; n_switch = 0; first_fired = -1;
    for (int f = 0; f < 102; f++) begin
      if (hist[f] == FIRED) begin n_fired++; if (first_fired < 0) first_fired = f; end
      if (hist[f] == SETTLE) n_settle++;
      if (hist[f] == SWITCH) n_switch++;
    end
    check("A fired frames", 32'(n_fired), 32'd30);
    check("A first fired frame", 32'(first_fired), 32'd11);
    check("A settle frames", 32'(n_settle), 32'd60);
    check("A switch frames", 32'(n_switch), 32'd1);
    check("A switch at frame 101", 32'(hist[101]), 32'(SWITCH));
    check("A phase after switch", 32'(a_ph), 32'(PLAY));
    check("A active after switch", 32'(a_act), 32'd1);
    check("A timer reloaded", 32'(a_tmr), 32'd600);
    check("A kcp1 live", 32'(a_kcp[15:8]), 32'h07);
    check("A kcp0 gated", 32'(a_kcp[7:0]), 32'h00);
    check_wind("A wind after switch", a_wind);
    a_kc = KEY_W;
    #1;
    check("A kcp1 zero latency", 32'(a_kcp[15:8]), 32'(KEY_W));

    // ---------------- Instance A: launch on the timeout frame ----------------
    repeat (600) frame();
    check("A timer at zero", 32'(a_tmr), 32'd0);
    check("A still PLAY at zero", 32'(a_ph), 32'(PLAY));
    a_bomb = 1'b1;
    frame();
    check("A launch beats timeout", 32'(a_ph), 32'(FIRED));
    check("A kcp in FIRED", 32'(a_kcp), 32'd0);

    // ---------------- Instance A: asynchronous reset while FIRED ----------------
    @(posedge clk);
    #2;
    a_rst = 1'b1;
    #1;
    check("A async reset phase", 32'(a_ph), 32'(PLAY));
    check("A async reset active", 32'(a_act), 32'd0);
    check("A async reset timer", 32'(a_tmr), 32'd600);
    a_bomb = 1'b0;
    frame();
    a_rst = 1'b0;
    a_kc = 8'h07;
    #1;
    check("A post reset kcp0", 32'(a_kcp[7:0]), 32'h07);

    // ---------------- Instance A: opponent dies on the timeout frame ----------------
    repeat (600) frame();
    check("A timer zero before death", 32'(a_tmr), 32'd0);
    a_dead = 2'b10;
    for (int f = 0; f < 70; f++) begin
      frame();
      hist2[f] = a_ph;
    end
    n_settle = 0;
    for (int f = 0; f < 70; f++) if (hist2[f] == SETTLE) n_settle++;
    check("A death settle frames", 32'(n_settle), 32'd60);
    check("A death switch frame", 32'(hist2[60]), 32'(SWITCH));
    check("A death over frame", 32'(hist2[61]), 32'(OVER));
    check("A game_over", 32'(a_go), 32'd1);
    check("A winner", 32'(a_win), 32'd0);
    check("A over kcp", 32'(a_kcp), 32'd0);
    a_bomb = 1'b1;
    frame();
    a_bomb = 1'b0;
    frame();
    check("A over absorbing", 32'(a_ph), 32'(OVER));

    // ---------------- Instance B: vector table ----------------
    add(0, 3'b000, KEY_D, PLAY,   0, 5, 0, 0);
    add(0, 3'b000, KEY_A, PLAY,   0, 4, 0, 0);
    add(0, 3'b000, KEY_W, PLAY,   0, 3, 0, 0);
    add(0, 3'b000, KEY_S, PLAY,   0, 2, 0, 0);
    add(0, 3'b000, KEY_D, PLAY,   0, 1, 0, 0);
    add(0, 3'b000, KEY_D, PLAY,   0, 0, 0, 0);
    add(0, 3'b000, KEY_A, SETTLE, 0, 0, 0, 0);
    add(0, 3'b000, KEY_A, SETTLE, 0, 0, 0, 0);
    add(0, 3'b010, KEY_A, SWITCH, 0, 0, 0, 0);
    add(1, 3'b010, KEY_W, PLAY,   2, 5, 0, 0);
    add(1, 3'b010, KEY_W, FIRED,  2, 5, 0, 0);
    add(0, 3'b010, KEY_W, FIRED,  2, 5, 0, 0);
    add(0, 3'b010, KEY_S, SETTLE, 2, 5, 0, 0);
    add(0, 3'b010, KEY_S, SETTLE, 2, 5, 0, 0);
    add(0, 3'b010, KEY_S, SWITCH, 2, 5, 0, 0);
    add(1, 3'b011, KEY_D, PLAY,   0, 5, 0, 0);
    add(1, 3'b011, KEY_D, SETTLE, 0, 5, 0, 0);
    add(1, 3'b011, KEY_D, SETTLE, 0, 5, 0, 0);
    add(1, 3'b011, KEY_D, SETTLE, 0, 5, 0, 0);
    add(0, 3'b011, KEY_D, SETTLE, 0, 5, 0, 0);
    add(0, 3'b011, KEY_A, SWITCH, 0, 5, 0, 0);
    add(1, 3'b011, KEY_A, OVER,   0, 5, 1, 2);
    add(0, 3'b011, KEY_A, OVER,   0, 5, 1, 2);

    b_rst = 1'b1; b_bomb = 1'b0; b_dead = '0;
    frame();
    b_rst = 1'b0;
    foreach (tv[i]) begin
      b_bomb = tv[i].bomb;
      b_dead = tv[i].dead;
      b_kc   = tv[i].kc;
      #1;
      check($sformatf("row%0d phase", i), 32'(b_ph), 32'(tv[i].ph));
      check($sformatf("row%0d active", i), 32'(b_act), 32'(tv[i].act));
      check($sformatf("row%0d timer", i), 32'(b_tmr), 32'(tv[i].tmr));
      check($sformatf("row%0d game_over", i), 32'(b_go), 32'(tv[i].go));
      check($sformatf("row%0d winner", i), 32'(b_win), 32'(tv[i].win));
      check($sformatf("row%0d keycode_p", i), 32'(b_kcp), 32'(exp_kcp(tv[i].ph, tv[i].act, tv[i].kc)));
      frame();
    end

    // ---------------- Instance B: randomized run against the model ----------------
    b_rst = 1'b1; b_bomb = 1'b0; b_dead = '0;
    frame();
    b_rst = 1'b0;
    model_reset();
    for (int f = 0; f < 3000; f++) begin
      check($sformatf("rand%0d phase", f), 32'(b_ph), 32'(m_phase));
      check($sformatf("rand%0d active", f), 32'(b_act), 32'(m_active));
      check($sformatf("rand%0d timer", f), 32'(b_tmr), 32'(TB - m_elapsed));
      check($sformatf("rand%0d game_over", f), 32'(b_go), 32'(m_over));
      check($sformatf("rand%0d winner", f), 32'(b_win), 32'(m_winner));
      check_wind($sformatf("rand%0d wind", f), b_wind);
      if ((m_phase == OVER && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        b_rst = 1'b1; b_bomb = 1'b0; b_dead = '0;
        frame();
        b_rst = 1'b0;
        model_reset();
      end else begin
        if ($urandom_range(0, 5) == 0) b_bomb = ~b_bomb;
        if ($urandom_range(0, 39) == 0) b_dead[$urandom_range(0, NB - 1)] = 1'b1;
        b_kc = 8'($urandom);
        #1;
        check($sformatf("rand%0d keycode_p", f), 32'(b_kcp), 32'(exp_kcp(m_phase, m_active, b_kc)));
        model_step(b_bomb, b_dead);
        frame();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
